// File: rtl/sudoku_check_sequencer.sv
// Sudoku grid check sequencer.
// Walks the 9 rows, 9 columns and 9 boxes of a 9x9 grid through a registered
// read port (one cell per cycle) and latches the first rule violation found.
module sudoku_check_sequencer #(
   parameter bit ALLOW_EMPTY  = 1'b1,
   parameter bit ABORT_ON_ERR = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [3:0] rd_row,
   output logic [3:0] rd_col,
   input  logic [3:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_kind,
   output logic [1:0] err_unit_type,
   output logic [3:0] err_unit_idx,
   output logic [3:0] err_cell_row,
   output logic [3:0] err_cell_col
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t     state, state_next;

   logic [1:0] t;
   logic [3:0] u, p;
   logic [3:0] box_row_base, box_col_base;
   logic [1:0] sub_row, sub_col;
   logic       last_addr;
   logic [3:0] addr_row, addr_col;

   logic       eval_valid;
   logic       eval_on;
   logic [1:0] t_d;
   logic [3:0] u_d, p_d, row_d, col_d;

   logic [8:0] mask, cur_mask, mask_next, onehot;
   logic       err_hit;
   logic [1:0] hit_kind;

   assign last_addr = (t == 2'd2) && (u == 4'd8) && (p == 4'd8);
   assign busy      = (state == SCAN) || (state == DRAIN);
   assign done      = (state == DONE);
   assign rd_row    = addr_row;
   assign rd_col    = addr_col;
   assign eval_on   = eval_valid && busy;

   // Map the unit/cell counters onto a grid address; idle address is (0,0).
   always_comb begin
      addr_row = 4'd0;
      addr_col = 4'd0;
      if (state == SCAN) begin
         case (t)
            2'd0: begin
               addr_row = u;
               addr_col = p;
            end
            2'd1: begin
               addr_row = p;
               addr_col = u;
            end
            default: begin
               addr_row = box_row_base + {2'b00, sub_row};
               addr_col = box_col_base + {2'b00, sub_col};
            end
         endcase
      end
   end

   // Evaluate the cell value returned for last cycle's address.
   always_comb begin
      cur_mask  = (p_d == 4'd0) ? 9'd0 : mask;
      onehot    = 9'd1 << (rd_data - 4'd1);
      mask_next = cur_mask;
      err_hit   = 1'b0;
      hit_kind  = 2'b00;
      if (eval_on) begin
         if (rd_data == 4'd0) begin
            if (!ALLOW_EMPTY) begin
               err_hit  = 1'b1;
               hit_kind = 2'b11;
            end
         end else if (rd_data > 4'd9) begin
            err_hit  = 1'b1;
            hit_kind = 2'b10;
         end else begin
            if ((cur_mask & onehot) != 9'd0) begin
               err_hit  = 1'b1;
               hit_kind = 2'b01;
            end
            mask_next = cur_mask | onehot;
         end
      end
   end

   // Next-state logic for the scan sequence.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SCAN;
         SCAN: begin
            if (ABORT_ON_ERR && err_hit) state_next = DONE;
            else if (last_addr)          state_next = DRAIN;
         end
         DRAIN:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Unit/cell counters, with box base/sub counters stepped alongside u and p.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start)) begin
         t            <= 2'd0;
         u            <= 4'd0;
         p            <= 4'd0;
         box_row_base <= 4'd0;
         box_col_base <= 4'd0;
         sub_row      <= 2'd0;
         sub_col      <= 2'd0;
      end else if (state == SCAN) begin
         if (p == 4'd8) begin
            p       <= 4'd0;
            sub_row <= 2'd0;
            sub_col <= 2'd0;
            if (u == 4'd8) begin
               u            <= 4'd0;
               t            <= t + 2'd1;
               box_row_base <= 4'd0;
               box_col_base <= 4'd0;
            end else begin
               u <= u + 4'd1;
               if (box_col_base == 4'd6) begin
                  box_col_base <= 4'd0;
                  box_row_base <= box_row_base + 4'd3;
               end else begin
                  box_col_base <= box_col_base + 4'd3;
               end
            end
         end else begin
            p <= p + 4'd1;
            if (sub_col == 2'd2) begin
               sub_col <= 2'd0;
               sub_row <= sub_row + 2'd1;
            end else begin
               sub_col <= sub_col + 2'd1;
            end
         end
      end
   end

   // Delay the address context by one cycle so it lines up with rd_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         eval_valid <= 1'b0;
         t_d        <= 2'd0;
         u_d        <= 4'd0;
         p_d        <= 4'd0;
         row_d      <= 4'd0;
         col_d      <= 4'd0;
      end else begin
         eval_valid <= (state == SCAN);
         t_d        <= t;
         u_d        <= u;
         p_d        <= p;
         row_d      <= addr_row;
         col_d      <= addr_col;
      end
   end

   // Seen-digit mask of the unit currently being evaluated.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start)) mask <= 9'd0;
      else if (eval_on)                    mask <= mask_next;
   end

   // Latch the first error of a scan; cleared only by rst or a new start.
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start)) begin
         err           <= 1'b0;
         err_kind      <= 2'b00;
         err_unit_type <= 2'b00;
         err_unit_idx  <= 4'd0;
         err_cell_row  <= 4'd0;
         err_cell_col  <= 4'd0;
      end else if (err_hit && !err) begin
         err           <= 1'b1;
         err_kind      <= hit_kind;
         err_unit_type <= t_d;
         err_unit_idx  <= u_d;
         err_cell_row  <= row_d;
         err_cell_col  <= col_d;
      end
   end

endmodule

// File: doc/sudoku_check_sequencer.md
# sudoku_check_sequencer

Controller that validates the stored 9x9 Sudoku grid. It walks all 27 constraint units (9 rows, then 9 columns, then 9 3x3 boxes) through the grid's registered read port, one cell per cycle. For each unit it tracks a 9-bit seen mask and reports the first rule violation. It sits beside the grid register array, and the top level drives it from the check trigger input and the status outputs.

## Interface
- ALLOW_EMPTY, default 1: 1 = value 0 is a blank cell and is skipped; 0 = value 0 is an error.
- ABORT_ON_ERR, default 0: 1 = end the scan right after the first error; 0 = always scan all 243 cells.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a scan. Sampled only in IDLE.
- rd_row  out  4  grid read row address, 0..8.
- rd_col  out  4  grid read column address, 0..8.
- rd_data  in  4  cell value for the address presented in the previous cycle.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan completes.
- err  out  1  sticky error flag for the last scan.
- err_kind  out  2  first error type: 00 none, 01 duplicate, 10 value >9, 11 disallowed empty.
- err_unit_type  out  2  unit where the first error occurred: 00 row, 01 column, 10 box.
- err_unit_idx  out  4  index of that unit, 0..8.
- err_cell_row / err_cell_col  out  4 each  coordinates of the cell that triggered the first error.

## Operation
- FSM states:
  - IDLE: if start, clear err and all err_* fields and the unit/cell counters, then go to SCAN.
  - SCAN: issue one address per cycle; after the 243rd address go to DRAIN.
  - DRAIN: evaluate the last read; go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- Counters: unit type t (0..2), unit index u (0..8), cell position p (0..8). p wraps 8->0 and increments u. u wraps 8->0 and increments t.
- Address mapping:
  - row unit: (u, p)
  - column unit: (p, u)
  - box unit: (3*(u/3) + p/3, 3*(u%3) + p%3)
  - Box coordinates come from base and sub counters. No dividers.
- Each read is evaluated one cycle after its address, using a registered copy of (t, u, p, row, col) that is aligned with rd_data.
- Evaluation of value v:
  - v=0: skip if ALLOW_EMPTY=1; otherwise error kind 11.
  - v>9: error kind 10. The mask is not updated.
  - 1..9: if mask[v-1] is already set, error kind 01. In all cases set mask[v-1].
- At p=0 the mask is replaced, not OR-ed: it becomes onehot(v), or 0 if v is blank or invalid.
- Error capture: the first error sets err and latches err_kind, err_unit_type, err_unit_idx, err_cell_row and err_cell_col. Later errors change nothing.
- With ABORT_ON_ERR=1, the cycle after an error is evaluated goes to DONE. Addresses issued in between are discarded.
- Results hold until the next accepted start or rst.
- start is ignored in SCAN, DRAIN and DONE.
- rd_row and rd_col are 0 when not in SCAN.

## Timing
- Reset values: busy=0, done=0, err=0, all err_* fields 0, rd_row=0, rd_col=0, state IDLE.
- rst asserted mid-scan: the next cycle shows reset values with no done pulse. rst has priority over start.
- start sampled high in IDLE at edge k:
  - busy=1 in cycles k+1..k+244.
  - Addresses are presented in cycles k+1..k+243, in order rows, columns, boxes.
  - DRAIN in cycle k+244.
  - done=1 and busy=0 in cycle k+245.
  - start is accepted again from cycle k+246.
- Error at the read addressed in cycle c: err and the err_* fields are visible in cycle c+2.
- With ABORT_ON_ERR=1: DONE, with done=1, in cycle c+2.
- Throughput: one cell per cycle with no stalls. The grid must provide 1-cycle read latency.
- err and the err_* fields are stable whenever done=1.

## Test plan
- All-zero grid, ALLOW_EMPTY=1, start at edge k -> address sequence matches the mapping (cycle k+1: (0,0); k+235: box 8 p=0 = (6,6)); done at k+245 with err=0.
- Valid solved grid -> err=0, err_kind=00; done pulse exactly one cycle long; start pulsed during busy is ignored.
- Zero grid plus 7 at (0,0) and (0,5) -> err=1, kind 01, unit row 0, cell (0,5).
- Zero grid plus 5 at (0,0) and (1,1) -> rows and columns pass; kind 01, unit box 0, cell (1,1), done at k+245.
- Value 12 at (8,8) with ABORT_ON_ERR=1 -> kind 10, unit row 8, cell (8,8); done 2 cycles after address (8,8), i.e. cycle k+83.
- rst asserted at cycle k+100 -> busy=0, all outputs at reset values, no done pulse; a new start runs a full 245-cycle scan. Repeat with ALLOW_EMPTY=0 on the zero grid -> kind 11, row 0, cell (0,0).
